// File: rtl/bridge_txn_fifo.sv
// ============================================================================
// Module   : bridge_txn_fifo
// Brief    : Single-clock transaction FIFO (data + address sideband) with
//            occupancy count, threshold flags, sticky errors and sync flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bridge_txn_fifo #(
  parameter int DSIZE    = 32,
  parameter int ASIZE    = 4,
  parameter int AWIDTH   = 32,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DSIZE-1:0]  wr_data,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic              rd_en,
  output logic [DSIZE-1:0]  rd_data,
  output logic [AWIDTH-1:0] rd_addr,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ASIZE:0]    count,
  output logic              overflow,
  output logic              underflow
);

  localparam int             c_depth    = 1 << ASIZE;
  localparam logic [ASIZE:0] c_full_cnt = (ASIZE+1)'(c_depth);
  localparam logic [ASIZE:0] c_af_cnt   = (ASIZE+1)'(AF_LEVEL);
  localparam logic [ASIZE:0] c_ae_cnt   = (ASIZE+1)'(AE_LEVEL);

  logic [DSIZE+AWIDTH-1:0] r_mem [c_depth];
  logic [ASIZE-1:0]        r_wptr;
  logic [ASIZE-1:0]        r_rptr;
  logic [ASIZE:0]          r_count;
  logic [DSIZE-1:0]        r_rd_data;
  logic [AWIDTH-1:0]       r_rd_addr;
  logic                    r_rd_valid;
  logic                    r_overflow;
  logic                    r_underflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Acceptance uses pre-edge flags, so a full FIFO rejects a simultaneous push.
  assign w_full  = (r_count == c_full_cnt);
  assign w_empty = (r_count == '0);
  assign w_push  = wr_en && !w_full && !clear;
  assign w_pop   = rd_en && !w_empty && !clear;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {wr_data, wr_addr};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_rd_data   <= '0;
      r_rd_addr   <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_rd_data   <= '0;
      r_rd_addr   <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_push) begin
        r_wptr <= r_wptr + ASIZE'(1);
      end
      if (w_pop) begin
        {r_rd_data, r_rd_addr} <= r_mem[r_rptr];
        r_rptr                 <= r_rptr + ASIZE'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (ASIZE+1)'(1);
        2'b01:   r_count <= r_count - (ASIZE+1)'(1);
        default: r_count <= r_count;
      endcase
      if (wr_en && w_full) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign rd_data      = r_rd_data;
  assign rd_addr      = r_rd_addr;
  assign rd_valid     = r_rd_valid;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= c_af_cnt);
  assign almost_empty = (r_count <= c_ae_cnt);

endmodule

`default_nettype wire

// File: tb/tb_bridge_txn_fifo.sv
// ============================================================================
// Module   : tb_bridge_txn_fifo
// Brief    : Directed scoreboard bench for bridge_txn_fifo.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bridge_txn_fifo;

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic        clear   = 1'b0;
  logic        wr_en   = 1'b0;
  logic        rd_en   = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] wr_addr = '0;
  logic [31:0] rd_data;
  logic [31:0] rd_addr;
  logic        rd_valid;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [4:0]  count;
  logic        overflow;
  logic        underflow;

  always #5 clk = ~clk;

  bridge_txn_fifo #(
    .DSIZE(32), .ASIZE(4), .AWIDTH(32), .AF_LEVEL(14), .AE_LEVEL(2)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .wr_en(wr_en), .wr_data(wr_data), .wr_addr(wr_addr),
    .rd_en(rd_en), .rd_data(rd_data), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  logic [63:0] mq[$];
  logic [63:0] sb[$];
  logic        exp_rv   = 1'b0;
  logic        exp_rv_q = 1'b0;
  int          n_vec    = 0;
  int          n_mis    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) exp_rv_q <= exp_rv;

  // Monitor: every rd_valid must match an expected pop, in order.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rd_valid || exp_rv_q) begin
      chk("rd_valid", 64'(rd_valid), 64'(exp_rv_q));
      if (rd_valid && exp_rv_q && sb.size() > 0) begin
        e = sb.pop_front();
        chk("rd_pair", {rd_data, rd_addr}, e);
      end
    end
  end

  task automatic cyc(input logic we, input logic [31:0] wd, input logic [31:0] wa,
                     input logic re, input logic clr);
    logic fm;
    logic em;
    fm = (mq.size() == 16);
    em = (mq.size() == 0);
    wr_en = we; wr_data = wd; wr_addr = wa; rd_en = re; clear = clr; exp_rv = 1'b0;
    if (clr) begin
      mq.delete();
    end else begin
      if (re && !em) begin
        sb.push_back(mq.pop_front());
        exp_rv = 1'b1;
      end
      if (we && !fm) mq.push_back({wd, wa});
    end
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0; exp_rv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_flags", {59'd0, full, empty, almost_full, almost_empty, rd_valid},
        {59'd0, 5'b01010});
    chk("rst_err", {62'd0, overflow, underflow}, 64'd0);

    // Fill with 16 entries.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 32'hA0 + 32'(i), 32'h1000 + 32'(4 * i), 1'b0, 1'b0);
      chk("fill_count", 64'(count), 64'(i + 1));
      chk("fill_af", 64'(almost_full), 64'((i + 1) >= 14));
    end
    chk("fill_full", 64'(full), 64'd1);

    cyc(1'b1, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_count", 64'(count), 64'd16);

    // Drain: A0..AF in order, never 0xDEAD.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("drain_data", 64'(rd_data), 64'(32'hA0 + 32'(i)));
    end
    chk("drain_empty", 64'(empty), 64'd1);

    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("unf_flag", 64'(underflow), 64'd1);
    chk("unf_valid", 64'(rd_valid), 64'd0);
    chk("unf_hold", {rd_data, rd_addr}, {32'hAF, 32'h103C});

    // Steady state at count 5 across pointer wrap.
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'hB0 + 32'(i), 32'h2000 + 32'(4 * i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 32'hC0 + 32'(i), 32'h2100 + 32'(4 * i), 1'b1, 1'b0);
      chk("ss_count", 64'(count), 64'd5);
      chk("ss_data", 64'(rd_data), (i < 5) ? 64'(32'hB0 + 32'(i)) : 64'(32'hC0 + 32'(i - 5)));
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("ss_tail", 64'(rd_data), 64'(32'hC0 + 32'(35 + i)));
    end

    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("clr_err", {62'd0, overflow, underflow}, 64'd0);

    // Simultaneous on empty.
    cyc(1'b1, 32'hE0, 32'h3000, 1'b1, 1'b0);
    chk("se_count", 64'(count), 64'd1);
    chk("se_unf", 64'(underflow), 64'd1);
    chk("se_valid", 64'(rd_valid), 64'd0);
    for (int i = 1; i < 16; i++) cyc(1'b1, 32'hE0 + 32'(i), 32'h3000 + 32'(4 * i), 1'b0, 1'b0);
    // Simultaneous on full.
    cyc(1'b1, 32'hF0, 32'h3F00, 1'b1, 1'b0);
    chk("sf_count", 64'(count), 64'd15);
    chk("sf_ovf", 64'(overflow), 64'd1);
    chk("sf_head", {rd_data, rd_addr}, {32'hE0, 32'h3000});
    for (int i = 1; i < 16; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("sf_empty", 64'(empty), 64'd1);

    // Flush with a concurrent push.
    for (int i = 0; i < 7; i++) cyc(1'b1, 32'hD0 + 32'(i), 32'h4000 + 32'(4 * i), 1'b0, 1'b0);
    cyc(1'b1, 32'h55, 32'h5555, 1'b0, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_flags", {59'd0, full, empty, almost_full, overflow, underflow},
        {59'd0, 5'b01000});
    chk("flush_rd", {rd_data, rd_addr}, 64'd0);
    cyc(1'b1, 32'h77, 32'h7000, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("flush_next", {rd_data, rd_addr}, {32'h77, 32'h7000});

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 7; i++) cyc(1'b1, 32'h90 + 32'(i), 32'h8000 + 32'(4 * i), 1'b0, 1'b0);
    wr_en = 1'b1; wr_data = 32'h99; wr_addr = 32'h9999;
    #2 rst = 1'b1;
    mq.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_empty", 64'(empty), 64'd1);
    chk("arst_rd", {rd_data, rd_addr}, 64'd0);
    cyc(1'b1, 32'h88, 32'h8800, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("arst_next", {rd_data, rd_addr}, {32'h88, 32'h8800});

    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bridge_txn_fifo.md
Name: bridge_txn_fifo

Overview:
- Parametrised single-clock FIFO that buffers AHB write transactions (data plus 32-bit address sideband) ahead of the APB master in the AHB-to-APB bridge.
- Replaces the bare dual-port storage array with full pointer management, occupancy count and registered read data.
- Adds programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush.

Parameters:
- DSIZE, 32: data word width in bits.
- ASIZE, 4: pointer width; DEPTH = 2**ASIZE entries (16).
- AWIDTH, 32: address sideband width stored with each entry.
- AF_LEVEL, 14: almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH-1.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.

Ports:
- clk  in  1  single clock for all logic, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush, active-high.
- wr_en  in  1  push strobe.
- wr_data  in  DSIZE  push data.
- wr_addr  in  AWIDTH  push address sideband.
- rd_en  in  1  pop strobe.
- rd_data  out  DSIZE  registered pop data.
- rd_addr  out  AWIDTH  registered pop address.
- rd_valid  out  1  one-cycle pulse marking a fresh rd_data/rd_addr.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ASIZE+1  number of stored entries, 0..DEPTH.
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: pop attempted while empty.

Behaviour:
Reset and flush:
- rst (asynchronous) drives rd_data, rd_addr, rd_valid, count, overflow and underflow to 0, and both pointers to 0.
- Out of reset: empty=1, almost_empty=1, full=0, almost_full=0.
- Storage array is not reset; its contents are don't-care until written.
- clear at an edge has the same effect as rst, synchronously, and takes priority over wr_en/rd_en in that cycle.
- rst asserted mid-operation discards all entries; the first push after release lands at address 0.

Push and pop:
- Push accepted = wr_en && !full. On acceptance, {wr_data, wr_addr} is written at wptr and wptr increments.
- Pop accepted = rd_en && !empty. On acceptance, the entry at rptr is registered into rd_data/rd_addr at that edge, rd_valid=1 for exactly the following cycle, and rptr increments.
- Pop latency: one clock from rd_en to data.
- rd_data/rd_addr hold their last value when no pop occurs; they are not zeroed.
- Pointers wrap modulo DEPTH. full/empty are derived from count, not from pointer compare.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Flags (full, empty, almost_full, almost_empty) are combinational on registered count and reflect the post-edge count.

Boundary conditions:
- wr_en while full: push ignored, contents unchanged, overflow set (sticky).
- rd_en while empty: pop ignored, rd_valid stays 0, rd_data holds, underflow set (sticky).
- wr_en && rd_en while full: pop accepted; push rejected (flags use the pre-edge state); overflow set; count = DEPTH-1.
- wr_en && rd_en while empty: push accepted; pop rejected; underflow set; count = 1. There is no write-to-read bypass.
- wr_en && rd_en otherwise: both accepted; the old head is read; count unchanged.
- overflow and underflow clear only on rst or clear.

Test Plan:
- Reset, then push 0xA0..0xAF with addresses 0x1000+4*i (16 entries). Required: full=1 after the 16th edge, count=16, almost_full first seen at count=14. Pop all 16: rd_data 0xA0..0xAF in order, each with its address, each rd_valid exactly one cycle after its rd_en; empty=1 at the end.
- With the FIFO full, assert wr_en with 0xDEAD. Required: overflow=1, count stays 16, and draining never returns 0xDEAD.
- With the FIFO empty, pulse rd_en. Required: underflow=1, rd_valid=0, rd_data unchanged.
- Simultaneous push/pop at count=5 for 40 cycles (exercises pointer wrap). Required: count holds at 5 and the popped sequence equals the pushed sequence delayed by 5 entries.
- Simultaneous wr_en/rd_en when empty. Required: count=1, underflow=1, no rd_valid. The same when full: count=15, overflow=1, rd_valid pulses with the head entry.
- Push 7 entries, then assert clear with wr_en high. Required: count=0, empty=1, flags=0; the next push is read back first. Repeat using rst asserted mid-stream, with the same result.
